// File: rtl/irq_arbiter_pkg.sv
// Shared types and field widths for the interrupt arbiter and its generator link.
package irq_arbiter_pkg;
    localparam int VEC_W = 12;
    localparam int FNC_W = 8;
    localparam int IDX_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ARMED,
        ST_WAIT,
        ST_DONE
    } state_t;
endpackage

// File: rtl/irq_arbiter_if.sv
// Link between the arbiter (master) and the IRQ generator (slave).
interface irq_arbiter_if;
    import irq_arbiter_pkg::*;

    logic [VEC_W-1:0] irq_vec;
    logic [FNC_W-1:0] irq_fnc;
    logic             irq_trig;
    logic             irq_recv;
    logic             irq_ack;
    logic             irq_fail;

    modport master (
        output irq_vec, irq_fnc, irq_trig,
        input  irq_recv, irq_ack, irq_fail
    );

    modport slave (
        input  irq_vec, irq_fnc, irq_trig,
        output irq_recv, irq_ack, irq_fail
    );
endinterface

// File: rtl/irq_arbiter_rr_pick.sv
// Combinational round-robin selector: first set pending bit at or after ptr_i, wrapping.
module rr_pick
    import irq_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);
    localparam logic [IDX_W:0] NUM_L = (IDX_W+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     off;
    logic [IDX_W:0]       sum;

    always_comb begin
        dbl = {pending_i, pending_i} >> ptr_i;
        rot = dbl[NUM_REQ-1:0];
        off = '0;
        // Descending scan so the smallest offset from the pointer wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = IDX_W'(k);
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= NUM_L) sum = sum - NUM_L;
        idx_o = sum[IDX_W-1:0];
        any_o = |pending_i;
    end
endmodule

// File: rtl/irq_arbiter.sv
// Round-robin interrupt arbiter: latches per-requester vec/fnc, issues one at a time to
// the IRQ generator with timeout and bounded retry, and reports each completion.
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 31
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [VEC_W*NUM_REQ-1:0] req_vec,
    input  logic [FNC_W*NUM_REQ-1:0] req_fnc,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     done_valid,
    output logic [IDX_W-1:0]         done_id,
    output logic                     done_fail,
    irq_arbiter_if.master            gen
);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   slot_q, slot_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               fail_q, fail_d;
    logic [VEC_W-1:0]   irq_vec_q, irq_vec_d;
    logic [FNC_W-1:0]   irq_fnc_q, irq_fnc_d;

    logic [VEC_W-1:0]   vec_mem_q [NUM_REQ];
    logic [FNC_W-1:0]   fnc_mem_q [NUM_REQ];

    logic [NUM_REQ-1:0] accept;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               attempt_fail;

    assign accept = req_valid & ~pending_q;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .pending_i (pending_q),
        .ptr_i     (rr_ptr_q),
        .idx_o     (pick_idx),
        .any_o     (pick_any)
    );

    // Slot payload is only meaningful while pending, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                vec_mem_q[i] <= req_vec[VEC_W*i +: VEC_W];
                fnc_mem_q[i] <= req_fnc[FNC_W*i +: FNC_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q | accept;
        rr_ptr_d     = rr_ptr_q;
        slot_d       = slot_q;
        retry_d      = retry_q;
        tmo_d        = tmo_q;
        fail_d       = fail_q;
        irq_vec_d    = irq_vec_q;
        irq_fnc_d    = irq_fnc_q;
        attempt_fail = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    slot_d = pick_idx;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (pick_idx == IDX_W'(i)) begin
                            irq_vec_d = vec_mem_q[i];
                            irq_fnc_d = fnc_mem_q[i];
                        end
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                state_d = ST_ARMED;
            end
            ST_ARMED, ST_WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (state_q == ST_ARMED && gen.irq_recv) begin
                    state_d = ST_WAIT;
                end
                // A resolved response takes precedence over a coincident timeout.
                if (state_q == ST_WAIT && !gen.irq_recv) begin
                    if (gen.irq_ack) begin
                        fail_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        attempt_fail = 1'b1;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    attempt_fail = 1'b1;
                end
                if (attempt_fail) begin
                    if (retry_q < RTY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = ST_ISSUE;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (slot_q == IDX_W'(i)) pending_d[i] = 1'b0;
                end
                retry_d  = '0;
                rr_ptr_d = (slot_q == IDX_W'(NUM_REQ - 1)) ? '0 : slot_q + IDX_W'(1);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            rr_ptr_q  <= '0;
            slot_q    <= '0;
            retry_q   <= '0;
            tmo_q     <= '0;
            fail_q    <= 1'b0;
            irq_vec_q <= '0;
            irq_fnc_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            slot_q    <= slot_d;
            retry_q   <= retry_d;
            tmo_q     <= tmo_d;
            fail_q    <= fail_d;
            irq_vec_q <= irq_vec_d;
            irq_fnc_q <= irq_fnc_d;
        end
    end

    assign req_ready    = ~pending_q;
    assign done_valid   = (state_q == ST_DONE);
    assign done_fail    = done_valid & fail_q;
    assign done_id      = done_valid ? slot_q : '0;
    assign gen.irq_trig = (state_q == ST_ISSUE);
    assign gen.irq_vec  = irq_vec_q;
    assign gen.irq_fnc  = irq_fnc_q;
endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboard bench for irq_arbiter: expected issues/completions are queued by the
// stimulus and consumed by a monitor; a small generator model answers each trigger.
module tb_irq_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [47:0] req_vec = '0;
    logic [31:0] req_fnc = '0;
    logic [3:0]  req_ready;
    logic        done_valid;
    logic [2:0]  done_id;
    logic        done_fail;

    irq_arbiter_if gen ();

    irq_arbiter #(.NUM_REQ(4), .MAX_RETRY(3), .TIMEOUT(31)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_vec    (req_vec),
        .req_fnc    (req_fnc),
        .req_ready  (req_ready),
        .done_valid (done_valid),
        .done_id    (done_id),
        .done_fail  (done_fail),
        .gen        (gen)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int trig_cnt = 0;
    int trig_cyc[$];
    logic [19:0] exp_issue[$];  // {vec, fnc}
    logic [3:0]  exp_done[$];   // {id, fail}

    // Generator behaviour: 0 = ack (after fails_left failures), 1 = ignore, 2 = hold busy.
    int gen_mode = 0;
    int fails_left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard.
    initial forever begin
        logic [19:0] ei;
        logic [3:0]  ed;
        @(negedge clk);
        cyc++;
        if (!rst && gen.irq_trig) begin
            trig_cnt++;
            trig_cyc.push_back(cyc);
            if (exp_issue.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_trig: vec 0x%0h, expected no issue", gen.irq_vec);
            end else begin
                ei = exp_issue.pop_front();
                chk("issue_vec", 32'(gen.irq_vec), 32'(ei[19:8]));
                chk("issue_fnc", 32'(gen.irq_fnc), 32'(ei[7:0]));
            end
        end
        if (!rst && done_valid) begin
            if (exp_done.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: id %0d, expected no completion", done_id);
            end else begin
                ed = exp_done.pop_front();
                chk("done_id", 32'(done_id), 32'(ed[3:1]));
                chk("done_fail", 32'(done_fail), 32'(ed[0]));
            end
        end
    end

    // Generator model.
    initial begin
        gen.irq_recv = 1'b0;
        gen.irq_ack  = 1'b0;
        gen.irq_fail = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && gen.irq_trig && gen_mode != 1) begin
                repeat (2) @(negedge clk);
                gen.irq_recv = 1'b1;
                gen.irq_ack  = 1'b0;
                gen.irq_fail = 1'b0;
                @(negedge clk);
                while (gen_mode == 2) @(negedge clk);
                gen.irq_recv = 1'b0;
                if (fails_left > 0) begin
                    fails_left--;
                    gen.irq_fail = 1'b1;
                end else begin
                    gen.irq_ack = 1'b1;
                end
            end
        end
    end

    task automatic send(input int i, input logic [11:0] v, input logic [7:0] f);
        @(negedge clk);
        chk("ready_before_req", 32'(req_ready[i]), 32'd1);
        req_valid[i] = 1'b1;
        req_vec[12*i +: 12] = v;
        req_fnc[8*i +: 8] = f;
        @(negedge clk);
        req_valid[i] = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_issue.size() != 0 || exp_done.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: issues left %0d, completions left %0d, expected 0",
                     exp_issue.size(), exp_done.size());
            exp_issue.delete();
            exp_done.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_valid && n < budget);
        checks++;
        if (!done_valid) begin
            errors++;
            $display("FAIL wait_done_timeout: done_valid 0 after %0d cycles, expected 1", n);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'hF);
        chk("rst_trig", 32'(gen.irq_trig), 32'd0);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_done_fail", 32'(done_fail), 32'd0);
        chk("rst_irq_vec", 32'(gen.irq_vec), 32'd0);
        chk("rst_irq_fnc", 32'(gen.irq_fnc), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        int base;
        // Reset state
        repeat (2) @(negedge clk);
        pulse_reset();

        // Single request
        base = trig_cnt;
        exp_issue.push_back({12'h005, 8'h01});
        exp_done.push_back({3'd0, 1'b0});
        send(0, 12'h005, 8'h01);
        drain(100);
        chk("single_trig_count", 32'(trig_cnt - base), 32'd1);

        // Fairness from rr_ptr = 0, then a re-request of 0 goes behind 3
        pulse_reset();
        for (int i = 0; i < 4; i++) exp_issue.push_back({12'h100 + 12'(i), 8'h10 + 8'(i)});
        exp_issue.push_back({12'h1AA, 8'h55});
        for (int i = 0; i < 4; i++) exp_done.push_back({3'(i), 1'b0});
        exp_done.push_back({3'd0, 1'b0});
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = 1'b1;
            req_vec[12*i +: 12] = 12'h100 + 12'(i);
            req_fnc[8*i +: 8] = 8'h10 + 8'(i);
        end
        @(negedge clk);
        req_valid = '0;
        for (int n = 0; n < 60 && !req_ready[0]; n++) @(negedge clk);
        send(0, 12'h1AA, 8'h55);
        drain(200);

        // Retry: two failures then ack
        base = trig_cnt;
        fails_left = 2;
        for (int k = 0; k < 3; k++) exp_issue.push_back({12'h2C3, 8'h7E});
        exp_done.push_back({3'd2, 1'b0});
        send(2, 12'h2C3, 8'h7E);
        drain(150);
        chk("retry_trig_count", 32'(trig_cnt - base), 32'd3);

        // Exhausted retries: generator never responds
        gen_mode = 1;
        base = trig_cnt;
        trig_cyc.delete();
        for (int k = 0; k < 4; k++) exp_issue.push_back({12'h3F1, 8'hA5});
        exp_done.push_back({3'd1, 1'b1});
        send(1, 12'h3F1, 8'hA5);
        wait_done(300);
        chk("exhaust_ready_in_done", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        chk("exhaust_ready_after", 32'(req_ready[1]), 32'd1);
        chk("exhaust_trig_count", 32'(trig_cnt - base), 32'd4);
        if (trig_cyc.size() == 4)
            chk("exhaust_attempt_span", 32'(trig_cyc[3] - trig_cyc[0]), 32'd96);
        drain(20);
        gen_mode = 0;

        // Reset while the generator holds irq_recv (arbiter in WAIT)
        gen_mode = 2;
        exp_issue.push_back({12'h0BE, 8'hEF});
        send(0, 12'h0BE, 8'hEF);
        drain(20);
        repeat (4) @(negedge clk);
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_done_valid", 32'(done_valid), 32'd0);
            chk("post_rst_trig", 32'(gen.irq_trig), 32'd0);
        end
        gen_mode = 0;
        repeat (2) @(negedge clk);
        exp_issue.push_back({12'h777, 8'h33});
        exp_done.push_back({3'd3, 1'b0});
        send(3, 12'h777, 8'h33);
        drain(100);

        // Acceptance boundary: req_valid[3] held through its own completion
        exp_issue.push_back({12'hA01, 8'h0A});
        exp_issue.push_back({12'hB02, 8'h0B});
        exp_done.push_back({3'd3, 1'b0});
        exp_done.push_back({3'd3, 1'b0});
        @(negedge clk);
        req_valid[3] = 1'b1;
        req_vec[47:36] = 12'hA01;
        req_fnc[31:24] = 8'h0A;
        wait_done(100);
        chk("boundary_ready_in_done", 32'(req_ready[3]), 32'd0);
        req_vec[47:36] = 12'hB02;
        req_fnc[31:24] = 8'h0B;
        @(negedge clk);
        chk("boundary_ready_after_done", 32'(req_ready[3]), 32'd1);
        @(negedge clk);
        chk("boundary_reaccepted", 32'(req_ready[3]), 32'd0);
        req_valid[3] = 1'b0;
        drain(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
